// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: registered N-to-log2(N) request encoder, fixed or round-robin per grant, valid/ready output
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   req   - request vector, bit i = requester i, sampled only when loading
//   mode  - 0 = fixed priority (highest index), 1 = round-robin
//   code  - encoded index of the granted requester
//   multi - more than one request bit was set in the sampled vector
//   valid - code/multi hold a result not yet accepted
//   ready - consumer accepts the result when valid && ready
module priority_encoder_rr #(
  parameter int N = 8,
  parameter int RESET_PTR = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic [W-1:0] code,
  output logic         multi,
  output logic         valid,
  input  logic         ready
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [W-1:0] code_q, code_d, ptr_q, ptr_d;
  logic multi_q, multi_d, rr_q, rr_d, accept, load;
  function automatic logic [W-1:0] hi_pick(input logic [N-1:0] r);
    hi_pick = '0;
    for (int i = 0; i < N; i++) if (r[i]) hi_pick = W'(i);
  endfunction
  // Scan from the farthest offset down so the nearest set bit at or after p wins.
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r, input logic [W-1:0] p);
    int j;
    rr_pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N) j = j - N;
      if (r[j]) rr_pick = W'(j);
    end
  endfunction
  always_comb begin
    accept  = (state_q == HOLD) && ready;
    load    = ((state_q == IDLE) || ready) && |req;
    // A round-robin grant moves the pointer only when it is accepted; a same-edge reload sees the new pointer.
    ptr_d   = (accept && rr_q) ? ((code_q == W'(N - 1)) ? '0 : code_q + 1'b1) : ptr_q;
    code_d  = load ? (mode ? rr_pick(req, ptr_d) : hi_pick(req)) : code_q;
    multi_d = load ? ($countones(req) > 1) : multi_q;
    rr_d    = load ? mode : rr_q;
    state_d = load ? HOLD : (accept ? IDLE : state_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      multi_q <= 1'b0;
      rr_q    <= 1'b0;
      ptr_q   <= W'(RESET_PTR);
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      rr_q    <= rr_d;
      ptr_q   <= ptr_d;
    end
  end
  assign code  = code_q;
  assign multi = multi_q;
  assign valid = (state_q == HOLD);
endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr: directed checks of fixed/round-robin encoding, back-pressure, wrap and async reset
module tb_priority_encoder_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = '0;
  logic mode = 1'b0, ready = 1'b0;
  logic [2:0] code;
  logic multi, valid;
  logic [4:0] req5 = '0;
  logic mode5 = 1'b0, ready5 = 1'b0;
  logic [2:0] code5;
  logic multi5, valid5;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  priority_encoder_rr #(.N(8), .RESET_PTR(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .code(code), .multi(multi), .valid(valid), .ready(ready)
  );
  priority_encoder_rr #(.N(5), .RESET_PTR(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5),
    .code(code5), .multi(multi5), .valid(valid5), .ready(ready5)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk3(input string tag, input int c, input int m, input int v);
    chk({tag, ".code"}, int'(code), c);
    chk({tag, ".multi"}, int'(multi), m);
    chk({tag, ".valid"}, int'(valid), v);
  endtask
  initial begin
    #3;
    chk3("reset", 0, 0, 0);
    chk("reset5.valid", int'(valid5), 0);
    #4 rst_n = 1'b1;
    step();
    chk3("idle", 0, 0, 0);
    req = 8'b1001_0010; mode = 1'b0; ready = 1'b1;
    step();
    chk3("fixed", 7, 1, 1);
    ready = 1'b0; req = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk3("stall", 7, 1, 1);
    end
    ready = 1'b1;
    step();
    chk3("release", 0, 0, 1);
    req = 8'h00;
    step();
    chk3("drain", 0, 0, 0);
    mode = 1'b1; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      chk3($sformatf("rr%0d", i), i % 8, 1, 1);
    end
    req = 8'b0010_0000;
    step();
    chk3("rr_to5", 5, 0, 1);
    req = 8'b0000_0101;
    step();
    chk3("rr_wrap", 0, 1, 1);
    step();
    chk3("rr_after_wrap", 2, 1, 1);
    mode = 1'b0; req = 8'h81;
    step();
    chk3("fixed_mid", 7, 1, 1);
    mode = 1'b1; req = 8'h11;
    step();
    chk3("fixed_keeps_ptr", 4, 1, 1);
    ready = 1'b0; req = 8'hFF;
    step();
    step();
    chk3("rr_stall", 4, 1, 1);
    ready = 1'b1; req = 8'h11;
    step();
    chk3("rr_after_stall", 0, 1, 1);
    ready = 1'b0;
    step();
    chk3("hold_before_rst", 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk3("async_rst", 0, 0, 0);
    #2 rst_n = 1'b1;
    req = 8'h11; mode = 1'b1; ready = 1'b1;
    step();
    chk3("post_rst_rr", 0, 1, 1);
    req5 = 5'b11111; mode5 = 1'b1; ready5 = 1'b1;
    step();
    chk("n5_first.code", int'(code5), 3);
    chk("n5_first.valid", int'(valid5), 1);
    step();
    chk("n5_grant4.code", int'(code5), 4);
    step();
    chk("n5_wrap.code", int'(code5), 0);
    chk("n5_wrap.multi", int'(multi5), 1);
    req5 = 5'b00000;
    step();
    chk("n5_drain.valid", int'(valid5), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
